// File: rtl/booth_pkg.sv
// Shared definitions for the Booth radix-2 sequential multiplier.
package booth_pkg;

    localparam int BOOTH_N_DEFAULT = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_EVAL  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_DONE  = 3'd4
    } booth_state_t;

    localparam logic PHASE_EVAL  = 1'b0;
    localparam logic PHASE_SHIFT = 1'b1;

endpackage

// File: rtl/booth_step.sv
// Combinational Booth step: add/subtract M in the eval phase, arithmetic
// right shift of {A,Q,Q_-1} in the shift phase. Holds no state.
module booth_step
    import booth_pkg::*;
#(
    parameter int N = BOOTH_N_DEFAULT
) (
    input  logic [N:0]   i_a,
    input  logic [N-1:0] i_q,
    input  logic         i_q_m1,
    input  logic [N-1:0] i_m,
    input  logic         i_phase,
    output logic [N:0]   o_a,
    output logic [N-1:0] o_q,
    output logic         o_q_m1
);

    // A is one bit wider than M so that subtracting M = -2^(N-1) cannot overflow
    logic [N:0] w_m_ext;
    assign w_m_ext = {i_m[N-1], i_m};

    always_comb begin
        o_a    = i_a;
        o_q    = i_q;
        o_q_m1 = i_q_m1;
        if (i_phase == PHASE_SHIFT) begin
            o_a    = {i_a[N], i_a[N:1]};
            o_q    = {i_a[0], i_q[N-1:1]};
            o_q_m1 = i_q[0];
        end else begin
            case ({i_q[0], i_q_m1})
                2'b01:   o_a = i_a + w_m_ext;
                2'b10:   o_a = i_a - w_m_ext;
                default: o_a = i_a;
            endcase
        end
    end

endmodule

// File: rtl/booth_seq_ctrl.sv
// Sequential Booth multiplier controller; owns all registers and steps
// the booth_step datapath once per EVAL/SHIFT cycle.
//
//   state | meaning
//   IDLE  | waiting for start; operands captured on accepted start
//   LOAD  | clear A, load iteration counter with N
//   EVAL  | add/subtract M into A according to {Q[0],Q_-1}
//   SHIFT | arithmetic shift {A,Q,Q_-1}, decrement counter
//   DONE  | product valid, held until ack
module booth_seq_ctrl
    import booth_pkg::*;
#(
    parameter int N = BOOTH_N_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           clear,
    input  logic [N-1:0]   multiplicand,
    input  logic [N-1:0]   multiplier,
    input  logic           ack,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int CW = $clog2(N + 1);

    booth_state_t   r_state;
    booth_state_t   w_state_nxt;
    logic [N:0]     r_a;
    logic [N-1:0]   r_q;
    logic           r_q_m1;
    logic [N-1:0]   r_m;
    logic [CW-1:0]  r_cnt;
    logic [2*N-1:0] r_product;

    logic [N:0]     w_a_nxt;
    logic [N-1:0]   w_q_nxt;
    logic           w_q_m1_nxt;
    logic [CW-1:0]  w_cnt_dec;
    logic           w_phase;

    assign w_cnt_dec = r_cnt - CW'(1);
    assign w_phase   = (r_state == ST_SHIFT) ? PHASE_SHIFT : PHASE_EVAL;

    booth_step #(.N(N)) u_step (
        .i_a     (r_a),
        .i_q     (r_q),
        .i_q_m1  (r_q_m1),
        .i_m     (r_m),
        .i_phase (w_phase),
        .o_a     (w_a_nxt),
        .o_q     (w_q_nxt),
        .o_q_m1  (w_q_m1_nxt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  w_state_nxt = start ? ST_LOAD : ST_IDLE;
                ST_LOAD:  w_state_nxt = ST_EVAL;
                ST_EVAL:  w_state_nxt = ST_SHIFT;
                ST_SHIFT: w_state_nxt = (w_cnt_dec == '0) ? ST_DONE : ST_EVAL;
                ST_DONE:  w_state_nxt = ack ? ST_IDLE : ST_DONE;
                default:  w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            ST_LOAD, ST_EVAL, ST_SHIFT: busy = 1'b1;
            ST_DONE:                    done = 1'b1;
            default:                    ;
        endcase
    end

    // clear gates every update so an aborted run leaves product untouched
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a       <= '0;
            r_q       <= '0;
            r_q_m1    <= 1'b0;
            r_m       <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else if (!clear) begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_m    <= multiplicand;
                        r_q    <= multiplier;
                        r_q_m1 <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    r_a   <= '0;
                    r_cnt <= CW'(N);
                end
                ST_EVAL: begin
                    r_a <= w_a_nxt;
                end
                ST_SHIFT: begin
                    r_a    <= w_a_nxt;
                    r_q    <= w_q_nxt;
                    r_q_m1 <= w_q_m1_nxt;
                    r_cnt  <= w_cnt_dec;
                    if (w_cnt_dec == '0) begin
                        r_product <= {w_a_nxt[N-1:0], w_q_nxt};
                    end
                end
                default: ;
            endcase
        end
    end

    assign product = r_product;

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Directed bench for booth_seq_ctrl (N=8): vector table plus corner sequences.
module tb_booth_seq_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        clear;
    logic [7:0]  multiplicand;
    logic [7:0]  multiplier;
    logic        ack;
    logic        busy;
    logic        done;
    logic [15:0] product;

    int checks = 0;
    int errors = 0;

    booth_seq_ctrl #(.N(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .clear        (clear),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .ack          (ack),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  mc;
        logic [7:0]  mp;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // start raised just after edge t; returns just after edge t+1 (state LOAD)
    task automatic do_start(input logic [7:0] mc, input logic [7:0] mp);
        tick();
        start        = 1'b1;
        multiplicand = mc;
        multiplier   = mp;
        tick();
        start        = 1'b0;
    endtask

    // counts further edges until done; busy must stay high meanwhile
    task automatic wait_done(output int n, output int busy_gaps);
        n = -1;
        busy_gaps = 0;
        for (int k = 0; k <= 40; k++) begin
            if (done) begin
                n = k;
                break;
            end
            if (!busy) busy_gaps++;
            tick();
        end
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    initial begin
        int n;
        int gaps;
        int bad;
        logic [15:0] held;

        vecs[0] = '{8'h03, 8'hFC, 16'hFFF4};
        vecs[1] = '{8'h80, 8'h80, 16'h4000};
        vecs[2] = '{8'h80, 8'h7F, 16'hC080};
        vecs[3] = '{8'h07, 8'h06, 16'h002A};
        vecs[4] = '{8'h00, 8'h37, 16'h0000};
        vecs[5] = '{8'hFF, 8'hFF, 16'h0001};
        vecs[6] = '{8'h7F, 8'h7F, 16'h3F01};
        vecs[7] = '{8'hFB, 8'h09, 16'hFFD3};
        vecs[8] = '{8'h01, 8'h80, 16'hFF80};

        rst = 1'b0; start = 1'b0; clear = 1'b0; ack = 1'b0;
        multiplicand = 8'h00; multiplier = 8'h00;
        #23;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_product", 32'(product), 32'd0);
        rst = 1'b1;
        tick();

        // done after edge t+18, i.e. 17 edges after the LOAD edge t+1
        foreach (vecs[i]) begin
            do_start(vecs[i].mc, vecs[i].mp);
            wait_done(n, gaps);
            chk($sformatf("vec%0d_latency", i), 32'(n), 32'd17);
            chk($sformatf("vec%0d_busy_gaps", i), 32'(gaps), 32'd0);
            chk($sformatf("vec%0d_product", i), 32'(product), 32'(vecs[i].exp));
            do_ack();
            chk($sformatf("vec%0d_idle_after_ack", i), 32'({busy, done}), 32'd0);
        end

        // start (and ack) while busy with new operands are ignored
        do_start(8'h07, 8'h06);
        repeat (4) tick();
        start = 1'b1; ack = 1'b1; multiplicand = 8'h64; multiplier = 8'hFD;
        tick();
        start = 1'b0; ack = 1'b0;
        wait_done(n, gaps);
        chk("busy_start_latency", 32'(n), 32'd12);
        chk("busy_start_product", 32'(product), 32'h002A);
        do_ack();

        // clear raised after t+5 -> IDLE after t+6, no done, product kept
        do_start(8'h09, 8'h09);
        repeat (4) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clear_idle", 32'({busy, done}), 32'd0);
        bad = 0;
        repeat (25) begin
            if (done || busy) bad++;
            tick();
        end
        chk("clear_no_done", 32'(bad), 32'd0);
        chk("clear_product_kept", 32'(product), 32'h002A);
        do_start(8'h03, 8'hFC);
        wait_done(n, gaps);
        chk("after_clear_latency", 32'(n), 32'd17);
        chk("after_clear_product", 32'(product), 32'hFFF4);
        do_ack();

        // done holds without ack; ack beats start in DONE
        do_start(8'h05, 8'h05);
        wait_done(n, gaps);
        held = product;
        chk("hold_product", 32'(held), 32'h0019);
        bad = 0;
        repeat (10) begin
            tick();
            if (!done || product !== 16'h0019) bad++;
        end
        chk("hold_10_cycles", 32'(bad), 32'd0);
        ack = 1'b1; start = 1'b1; multiplicand = 8'h02; multiplier = 8'h02;
        tick();
        ack = 1'b0; start = 1'b0;
        chk("ack_start_idle", 32'({busy, done}), 32'd0);
        bad = 0;
        repeat (5) begin
            tick();
            if (busy || done) bad++;
        end
        chk("ack_start_dropped", 32'(bad), 32'd0);
        chk("ack_start_product", 32'(product), 32'h0019);

        // asynchronous reset mid-operation, then a normal restart
        do_start(8'hF9, 8'h0B);
        repeat (8) tick();
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_done", 32'(done), 32'd0);
        chk("async_rst_product", 32'(product), 32'd0);
        tick();
        #2;
        rst = 1'b1;
        do_start(8'hF9, 8'h0B);
        wait_done(n, gaps);
        chk("restart_latency", 32'(n), 32'd17);
        chk("restart_product", 32'(product), 32'hFFB3);
        do_ack();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
